// File: rtl/frame_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : frame_buffer_arbiter
// Purpose  : Single-port frame-buffer RAM arbiter. Display reads win over
//            buffered edge-detector writes, and reads have a fixed latency.
// Revision : 1.0 - initial release
// ============================================================================
module frame_buffer_arbiter #(
    parameter int FIFO_DEPTH  = 4,
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_MAX    = 307199
) (
    input  logic        video_clk,
    input  logic        reset_n,
    input  logic        rd_req,
    input  logic [18:0] rd_addr,
    output logic [2:0]  rd_data,
    output logic        rd_valid,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [18:0] wr_addr,
    input  logic [2:0]  wr_data,
    output logic [18:0] mem_addr,
    output logic        mem_we,
    output logic [2:0]  mem_din,
    input  logic [2:0]  mem_dout,
    output logic [15:0] wr_stall_cnt
);

    localparam int               c_PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_PTR_W:0] c_DEPTH    = (c_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [18:0]      c_ADDR_MAX = 19'(ADDR_MAX);

    localparam logic [1:0] c_GNT_IDLE = 2'd0;
    localparam logic [1:0] c_GNT_RD   = 2'd1;
    localparam logic [1:0] c_GNT_WR   = 2'd2;

    logic [18:0]          r_fifo_addr [FIFO_DEPTH];
    logic [2:0]           r_fifo_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_PTR_W:0]     r_count;

    logic [18:0]          r_mem_addr;
    logic                 r_mem_we;
    logic [2:0]           r_mem_din;

    logic [MEM_LATENCY:0] r_vld_pipe;
    logic [MEM_LATENCY:0] r_oor_pipe;
    logic                 r_cap_vld;
    logic [2:0]           r_cap;
    logic                 r_rd_valid;
    logic [2:0]           r_rd_data;
    logic [15:0]          r_stall_cnt;

    logic [1:0]           w_gnt;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_rd_in_range;
    logic                 w_stall;

    // No bypass: a full FIFO refuses even when it is popping this cycle.
    assign wr_ready      = reset_n & (r_count < c_DEPTH);
    assign w_push        = wr_valid & wr_ready & (wr_addr <= c_ADDR_MAX);
    assign w_pop         = (w_gnt == c_GNT_WR);
    assign w_rd_in_range = rd_req & (rd_addr <= c_ADDR_MAX);
    assign w_stall       = wr_valid & ~wr_ready;

    always_comb begin
        w_gnt = c_GNT_IDLE;
        if (rd_req) begin
            w_gnt = c_GNT_RD;
        end else if (r_count != '0) begin
            w_gnt = c_GNT_WR;
        end
    end

    always_ff @(posedge video_clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= wr_addr;
            r_fifo_data[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge video_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + {{c_PTR_W{1'b0}}, w_push} - {{c_PTR_W{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge video_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_addr <= '0;
            r_mem_we   <= 1'b0;
            r_mem_din  <= '0;
        end else begin
            case (w_gnt)
                c_GNT_RD: begin
                    r_mem_we <= 1'b0;
                    if (w_rd_in_range) begin
                        r_mem_addr <= rd_addr;
                    end
                end
                c_GNT_WR: begin
                    r_mem_we   <= 1'b1;
                    r_mem_addr <= r_fifo_addr[r_rptr];
                    r_mem_din  <= r_fifo_data[r_rptr];
                end
                default: begin
                    r_mem_we <= 1'b0;
                end
            endcase
        end
    end

    // Stage MEM_LATENCY lines up with valid mem_dout; one capture stage then
    // one output stage give the fixed MEM_LATENCY+2 return latency.
    always_ff @(posedge video_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_pipe <= '0;
            r_oor_pipe <= '0;
            r_cap_vld  <= 1'b0;
            r_cap      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_vld_pipe[0] <= rd_req;
            r_oor_pipe[0] <= rd_req & ~w_rd_in_range;
            for (int i = 1; i <= MEM_LATENCY; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_oor_pipe[i] <= r_oor_pipe[i-1];
            end
            r_cap_vld <= r_vld_pipe[MEM_LATENCY];
            if (r_vld_pipe[MEM_LATENCY]) begin
                r_cap <= r_oor_pipe[MEM_LATENCY] ? 3'd0 : mem_dout;
            end
            r_rd_valid <= r_cap_vld;
            r_rd_data  <= r_cap;
        end
    end

    always_ff @(posedge video_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign mem_addr     = r_mem_addr;
    assign mem_we       = r_mem_we;
    assign mem_din      = r_mem_din;
    assign rd_valid     = r_rd_valid;
    assign rd_data      = r_rd_data;
    assign wr_stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_buffer_arbiter
// Purpose  : Randomized bench for frame_buffer_arbiter against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_buffer_arbiter;

    localparam int          c_DEPTH = 4;
    localparam int          c_LAT   = 2;
    localparam logic [18:0] c_AMAX  = 19'd307199;

    logic        video_clk = 1'b0;
    logic        reset_n;
    logic        rd_req;
    logic [18:0] rd_addr;
    logic [2:0]  rd_data;
    logic        rd_valid;
    logic        wr_valid;
    logic        wr_ready;
    logic [18:0] wr_addr;
    logic [2:0]  wr_data;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [2:0]  mem_din;
    logic [2:0]  mem_dout;
    logic [15:0] wr_stall_cnt;

    frame_buffer_arbiter #(
        .FIFO_DEPTH (c_DEPTH),
        .MEM_LATENCY(c_LAT),
        .ADDR_MAX   (307199)
    ) u_dut (
        .video_clk   (video_clk),
        .reset_n     (reset_n),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout),
        .wr_stall_cnt(wr_stall_cnt)
    );

    always #5 video_clk = ~video_clk;

    // RAM stub: 64 words aliased on the low address bits, c_LAT-cycle read.
    logic       ram_clr;
    logic [2:0] ram      [64];
    logic [2:0] ram_pipe [c_LAT];

    always @(posedge video_clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 64; i++) ram[i] <= 3'd0;
        end else if (mem_we) begin
            ram[mem_addr[5:0]] <= mem_din;
        end
        ram_pipe[0] <= ram[mem_addr[5:0]];
        for (int i = 1; i < c_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign mem_dout = ram_pipe[c_LAT-1];

    typedef struct packed {
        logic [18:0] a;
        logic [2:0]  d;
    } wr_t;

    typedef struct {
        int         due;
        logic [2:0] d;
    } rd_t;

    wr_t         fq[$];
    rd_t         pq[$];
    logic [2:0]  shadow [64];
    logic [18:0] m_addr;
    logic        m_we;
    logic [2:0]  m_din;
    int          m_stall;
    int          cyc;
    int          n_cmp;
    int          n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        fq.delete();
        pq.delete();
        m_addr  = '0;
        m_we    = 1'b0;
        m_din   = '0;
        m_stall = 0;
    endtask

    task automatic cycle(input logic rq, input logic [18:0] ra,
                         input logic wv, input logic [18:0] wa, input logic [2:0] wd);
        logic       rdy;
        logic       ev;
        logic [2:0] ed;
        rd_t        r;
        wr_t        h;
        @(negedge video_clk);
        rd_req   = rq;
        rd_addr  = ra;
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;

        rdy = (fq.size() < c_DEPTH);
        if (wv && !rdy && m_stall < 16'hFFFF) m_stall++;
        if (rq) begin
            m_we  = 1'b0;
            r.due = cyc + 1 + c_LAT + 2;
            if (ra <= c_AMAX) begin
                m_addr = ra;
                r.d    = shadow[ra[5:0]];
            end else begin
                r.d = 3'd0;
            end
            pq.push_back(r);
        end else if (fq.size() > 0) begin
            h      = fq.pop_front();
            m_we   = 1'b1;
            m_addr = h.a;
            m_din  = h.d;
            shadow[h.a[5:0]] = h.d;
        end else begin
            m_we = 1'b0;
        end
        if (wv && rdy && wa <= c_AMAX) begin
            h.a = wa;
            h.d = wd;
            fq.push_back(h);
        end

        @(posedge video_clk);
        #1;
        cyc++;
        ev = 1'b0;
        ed = 3'd0;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            ev = 1'b1;
            ed = pq[0].d;
            void'(pq.pop_front());
        end
        chk("mem_we",   32'(mem_we),   32'(m_we));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("mem_din",  32'(mem_din),  32'(m_din));
        chk("rd_valid", 32'(rd_valid), 32'(ev));
        if (ev) chk("rd_data", 32'(rd_data), 32'(ed));
        chk("wr_ready", 32'(wr_ready), 32'(fq.size() < c_DEPTH));
        chk("stall",    32'(wr_stall_cnt), 32'(m_stall));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 19'd0, 1'b0, 19'd0, 3'd0);
    endtask

    task automatic reset_pulse();
        @(negedge video_clk);
        rd_req   = 1'b0;
        wr_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_we",   32'(mem_we),   32'd0);
        chk("rst_mem_din",  32'(mem_din),  32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data",  32'(rd_data),  32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_stall",    32'(wr_stall_cnt), 32'd0);
        model_clear();
        #1 reset_n = 1'b1;
        #1;
        chk("rel_wr_ready", 32'(wr_ready), 32'd1);
    endtask

    function automatic logic [18:0] rnd_addr();
        if ($urandom_range(0, 9) == 0) return 19'($urandom_range(307200, 524287));
        return 19'($urandom_range(0, 63));
    endfunction

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        cyc      = 0;
        reset_n  = 1'b0;
        ram_clr  = 1'b1;
        rd_req   = 1'b0;
        rd_addr  = '0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        for (int i = 0; i < 64; i++) shadow[i] = 3'd0;
        model_clear();

        repeat (3) @(posedge video_clk);
        #1;
        chk("init_mem_addr", 32'(mem_addr), 32'd0);
        chk("init_mem_we",   32'(mem_we),   32'd0);
        chk("init_rd_valid", 32'(rd_valid), 32'd0);
        chk("init_wr_ready", 32'(wr_ready), 32'd0);
        chk("init_stall",    32'(wr_stall_cnt), 32'd0);
        @(negedge video_clk);
        reset_n = 1'b1;
        ram_clr = 1'b0;
        #1;
        chk("init_rel_ready", 32'(wr_ready), 32'd1);

        // Single write, then read-back latency
        cycle(1'b0, 19'd0, 1'b1, 19'd100, 3'b010);
        cycle(1'b0, 19'd0, 1'b0, 19'd0, 3'd0);
        chk("single_we",   32'(mem_we),   32'd1);
        chk("single_addr", 32'(mem_addr), 32'd100);
        chk("single_din",  32'(mem_din),  32'd2);
        cycle(1'b0, 19'd0, 1'b1, 19'd5, 3'b001);
        idle(2);
        cycle(1'b1, 19'd5, 1'b0, 19'd0, 3'd0);
        idle(6);

        // Range: out-of-range read and write, plus the top legal address
        cycle(1'b1, 19'd307200, 1'b0, 19'd0, 3'd0);
        cycle(1'b0, 19'd0, 1'b1, 19'd307200, 3'd7);
        cycle(1'b0, 19'd0, 1'b1, c_AMAX, 3'd6);
        cycle(1'b1, c_AMAX, 1'b0, 19'd0, 3'd0);
        cycle(1'b1, 19'd307200, 1'b0, 19'd0, 3'd0);
        idle(6);

        // Reset mid-operation: 3 queued writes, reads in flight
        for (int i = 0; i < 3; i++) cycle(1'b1, 19'(i), 1'b1, 19'(40 + i), 3'(i + 1));
        reset_pulse();
        idle(8);

        // Starvation: reads hold the port for 20 edges
        for (int i = 0; i < 20; i++) cycle(1'b1, 19'(i), 1'b1, 19'(20 + i), 3'(i + 3));
        chk("starve_stall", 32'(wr_stall_cnt), 32'd16);
        chk("starve_ready", 32'(wr_ready), 32'd0);
        idle(8);

        // Random traffic with bursty read phases
        for (int i = 0; i < 600; i++) begin
            int p;
            p = (i % 100 < 30) ? 90 : 30;
            cycle(($urandom_range(0, 99) < p), rnd_addr(),
                  1'($urandom_range(0, 1)), rnd_addr(), 3'($urandom_range(0, 7)));
        end
        idle(8);

        // Stall counter saturation
        for (int i = 0; i < 70010; i++) cycle(1'b1, 19'd1, 1'b1, 19'd2, 3'd3);
        chk("sat_stall", 32'(wr_stall_cnt), 32'hFFFF);
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_buffer_arbiter.md
FRAME_BUFFER_ARBITER -- requirements
Module: frame_buffer_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: write-buffer depth in entries, a power of two of at least 2.
REQ-002 Parameter MEM_LATENCY, default 2: RAM read latency in cycles, from registered mem_addr to valid mem_dout.
REQ-003 Parameter ADDR_MAX, default 307199: highest legal pixel address (640x480-1).
REQ-004 Port video_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port rd_req, input, 1 bit: the display requests one pixel read in this cycle.
REQ-007 Port rd_addr, input, 19 bits: pixel address for the read.
REQ-008 Port rd_data, output, 3 bits: returned pixel class.
REQ-009 Port rd_valid, output, 1 bit: rd_data is valid in this cycle.
REQ-010 Port wr_valid, input, 1 bit: the edge detector offers a write.
REQ-011 Port wr_ready, output, 1 bit: the block accepts the offered write in this cycle.
REQ-012 Port wr_addr, input, 19 bits: write address.
REQ-013 Port wr_data, input, 3 bits: write data.
REQ-014 Port mem_addr, output, 19 bits: single-port RAM address, registered.
REQ-015 Port mem_we, output, 1 bit: RAM write enable, registered.
REQ-016 Port mem_din, output, 3 bits: RAM write data, registered.
REQ-017 Port mem_dout, input, 3 bits: RAM read data.
REQ-018 Port wr_stall_cnt, output, 16 bits: saturating count of cycles in which a write was blocked.

Function
REQ-019 A write is accepted when wr_valid=1 and wr_ready=1 on the same edge; wr_ready SHALL equal (fifo_count < FIFO_DEPTH), with no bypass, so a full FIFO refuses a push even when it pops in the same cycle.
REQ-020 An accepted write with wr_addr<=ADDR_MAX SHALL be pushed to the FIFO; one with wr_addr>ADDR_MAX SHALL be accepted and discarded.
REQ-021 Arbitration SHALL be evaluated each edge from the pre-edge state with fixed priority:
- rd_req=1: issue a read.
- else FIFO non-empty: pop the head and write it.
- else idle.
REQ-022 Read issue SHALL register mem_addr=rd_addr and mem_we=0.
REQ-023 Write issue SHALL register mem_addr=head address, mem_din=head data and mem_we=1 for exactly one cycle per popped entry.
REQ-024 Idle SHALL register mem_we=0 and hold mem_addr and mem_din.
REQ-025 A read request at edge t SHALL produce rd_valid=1 for one cycle at edge t+MEM_LATENCY+2 (4 with the default), with rd_data registered from mem_dout; the latency is fixed and back-to-back requests yield back-to-back rd_valid.
REQ-026 A read with rd_addr>ADDR_MAX SHALL issue no RAM access (mem_we=0, mem_addr held) and SHALL still return rd_valid at the normal latency, with rd_data=0.
REQ-027 FIFO order SHALL be preserved; simultaneous push and pop SHALL leave fifo_count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 wr_stall_cnt SHALL increment on every edge where wr_valid=1 and wr_ready=0, and SHALL saturate at 16'hFFFF.
REQ-029 Read-after-write hazards are not forwarded: a read to an address still in the FIFO returns the RAM contents.
REQ-030 A write pushed at edge t into an empty FIFO with rd_req=0 at t+1 SHALL appear as mem_we=1 after edge t+1.

Reset
REQ-031 While reset_n=0, the block SHALL clear asynchronously:
- mem_addr=0, mem_we=0, mem_din=0
- rd_valid=0, rd_data=0
- the read-valid pipeline
- FIFO pointers and count
- wr_stall_cnt=0
REQ-032 While reset_n=0, wr_ready SHALL be 0.
REQ-033 Reads in flight and FIFO contents at reset assertion SHALL be discarded, with no rd_valid or mem_we afterwards for them.
REQ-034 After reset_n rises, the first edge SHALL operate normally, and wr_ready SHALL be 1.

Verification
REQ-035 Single write: FIFO empty, wr_valid=1, addr=100, data=3'b010 at edge t -> mem_we=1, mem_addr=100, mem_din=2 after edge t+1.
REQ-036 Read latency: write 3'b001 to addr 5, then rd_req=1, rd_addr=5 at edge t -> rd_valid=1, rd_data=1 after edge t+4, and rd_valid=0 elsewhere.
REQ-037 Starvation: rd_req held at 1 for 20 cycles, wr_valid held at 1 -> 4 writes accepted, wr_ready=0, wr_stall_cnt=16 after 20 edges, mem_we never 1; then drop rd_req -> 4 writes in FIFO order on consecutive cycles.
REQ-038 Range: rd_addr=307200 -> rd_valid after 4 edges, rd_data=0, no mem_addr change; wr_addr=307200 accepted -> no mem_we.
REQ-039 Saturation: force 70000 stall cycles -> wr_stall_cnt=16'hFFFF and holds.
REQ-040 Reset mid-operation: 3 FIFO entries and 2 reads in flight, pulse reset_n low between edges -> outputs 0 immediately; no mem_we or rd_valid after release until new requests arrive.
